// File: rtl/adder_bscan_pkg.sv
// Shared definitions for the boundary-scanned adder: chain length, cell
// positions along the scan path and the input/output cell classification.
package adder_bscan_pkg;

    typedef enum logic {
        CELL_IN  = 1'b0,
        CELL_OUT = 1'b1
    } cell_kind_e;

    // Operand a always sits next to tdi, so its base does not depend on width.
    localparam int A_BASE = 0;

    function automatic int chain_len(input int n);
        return 3 * n + 3;
    endfunction

    function automatic int b_base(input int n);
        return n;
    endfunction

    function automatic int cin_idx(input int n);
        return 2 * n;
    endfunction

    function automatic int sel_idx(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int sum_base(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int co_idx(input int n);
        return 3 * n + 2;
    endfunction

    // Everything upstream of the sum field drives the core; the rest observes it.
    function automatic cell_kind_e cell_kind(input int n, input int idx);
        return (idx < sum_base(n)) ? CELL_IN : CELL_OUT;
    endfunction

endpackage

// File: rtl/adder_bscan_top_bsc_cell.sv
// One boundary-scan cell: capture/shift register, update register and the
// functional/test mux on the data path.
module bsc_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic test_mode,
    input  logic data_in,
    input  logic scan_in,
    output logic scan_out,
    output logic data_out
);

    logic sr_q;
    logic ur_q;

    // Capture takes priority over shift; update samples the pre-edge SR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= 1'b0;
            ur_q <= 1'b0;
        end else begin
            if (capture) begin
                sr_q <= data_in;
            end else if (shift) begin
                sr_q <= scan_in;
            end
            if (update) begin
                ur_q <= sr_q;
            end
        end
    end

    assign scan_out = sr_q;
    assign data_out = test_mode ? ur_q : data_in;

endmodule

// File: rtl/adder_bscan_top.sv
// N-bit add/subtract core wrapped in a boundary-scan chain covering every
// operand, control and result pin.
module adder_bscan_top
    import adder_bscan_pkg::*;
#(
    parameter int N       = 16,
    parameter int OUT_REG = 1
) (
    input  logic         pin_clk,
    input  logic         pin_rst_n,
    input  logic [N-1:0] pin_a,
    input  logic [N-1:0] pin_b,
    input  logic         pin_cin,
    input  logic         pin_sel,
    output logic [N-1:0] pin_sum,
    output logic         pin_co,
    input  logic         pin_tdi,
    output logic         pin_tdo,
    input  logic         pin_capture,
    input  logic         pin_shift,
    input  logic         pin_update,
    input  logic         pin_test_mode
);

    localparam int L        = chain_len(N);
    localparam int B_BASE   = b_base(N);
    localparam int CIN_IDX  = cin_idx(N);
    localparam int SEL_IDX  = sel_idx(N);
    localparam int SUM_BASE = sum_base(N);
    localparam int CO_IDX   = co_idx(N);

    logic [L:0]          scan;
    logic [SUM_BASE-1:0] in_pin;
    logic [SUM_BASE-1:0] in_core;
    logic [N:0]          out_core;
    logic [N:0]          out_pin;

    logic [N-1:0] core_a;
    logic [N-1:0] core_b;
    logic         core_cin;
    logic         core_sel;
    logic [N:0]   res_p0;

    assign scan[0] = pin_tdi;
    assign pin_tdo = scan[L];
    assign in_pin  = {pin_sel, pin_cin, pin_b, pin_a};

    // Input and output cells live in separate vectors so the core path
    // through the cell muxes never forms a loop on a single net.
    for (genvar i = 0; i < L; i++) begin : g_cell
        if (cell_kind(N, i) == CELL_IN) begin : g_in
            bsc_cell u_cell (
                .clk       (pin_clk),
                .rst_n     (pin_rst_n),
                .capture   (pin_capture),
                .shift     (pin_shift),
                .update    (pin_update),
                .test_mode (pin_test_mode),
                .data_in   (in_pin[i]),
                .scan_in   (scan[i]),
                .scan_out  (scan[i+1]),
                .data_out  (in_core[i])
            );
        end else begin : g_out
            bsc_cell u_cell (
                .clk       (pin_clk),
                .rst_n     (pin_rst_n),
                .capture   (pin_capture),
                .shift     (pin_shift),
                .update    (pin_update),
                .test_mode (pin_test_mode),
                .data_in   (out_core[i-SUM_BASE]),
                .scan_in   (scan[i]),
                .scan_out  (scan[i+1]),
                .data_out  (out_pin[i-SUM_BASE])
            );
        end
    end

    assign core_a   = in_core[A_BASE +: N];
    assign core_b   = in_core[B_BASE +: N];
    assign core_cin = in_core[CIN_IDX];
    assign core_sel = in_core[SEL_IDX];

    // Stage p0: subtract is a + ~b + 1, carry-in ignored; co=1 means no borrow.
    always_comb begin
        res_p0 = '0;
        if (core_sel) begin
            res_p0 = {1'b0, core_a} + {1'b0, ~core_b} + {{N{1'b0}}, 1'b1};
        end else begin
            res_p0 = {1'b0, core_a} + {1'b0, core_b} + {{N{1'b0}}, core_cin};
        end
    end

    // Stage p1: optional result register, loaded every cycle.
    if (OUT_REG != 0) begin : g_reg
        logic [N:0] res_p1;
        always_ff @(posedge pin_clk) begin
            if (!pin_rst_n) begin
                res_p1 <= '0;
            end else begin
                res_p1 <= res_p0;
            end
        end
        assign out_core = res_p1;
    end else begin : g_comb
        assign out_core = res_p0;
    end

    assign pin_sum = out_pin[N-1:0];
    assign pin_co  = out_pin[N];

endmodule

// File: tb/tb_adder_bscan_top.sv
// Scoreboard bench: stimulus queues expected pin values per cycle, a monitor
// compares them on the falling edge against a plain-arithmetic model.
module tb_adder_bscan_top;

    localparam int N = 16;
    localparam int L = 3 * N + 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] a, b;
    logic         cin, sel, tdi, capture, shift, update, test_mode;
    logic [N-1:0] sum;
    logic         co, tdo;

    always #5 clk = ~clk;

    adder_bscan_top #(.N(N), .OUT_REG(1)) dut (
        .pin_clk       (clk),
        .pin_rst_n     (rst_n),
        .pin_a         (a),
        .pin_b         (b),
        .pin_cin       (cin),
        .pin_sel       (sel),
        .pin_sum       (sum),
        .pin_co        (co),
        .pin_tdi       (tdi),
        .pin_tdo       (tdo),
        .pin_capture   (capture),
        .pin_shift     (shift),
        .pin_update    (update),
        .pin_test_mode (test_mode)
    );

    typedef struct {
        int         cyc;
        bit         is_scan;
        logic [N:0] exp;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N:0] ref_sum(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic ci, input logic sub);
        longint unsigned r;
        longint unsigned xv = x;
        longint unsigned yv = y;
        if (sub) r = xv + ((64'd1 << N) - yv);
        else     r = xv + yv + ci;
        return r[N:0];
    endfunction

    function automatic logic [L-1:0] chain_img(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic ci, input logic sub,
                                               input logic [N:0] cs);
        return {cs[N], cs[N-1:0], sub, ci, y, x};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int lat, input bit is_scan, input logic [N:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + lat; e.is_scan = is_scan; e.exp = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic apply(input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic ci, input logic sub, input string nm);
        a = x; b = y; cin = ci; sel = sub;
        if (!test_mode) expect_at(1, 1'b0, ref_sum(x, y, ci, sub), nm);
        step();
    endtask

    // Called on the cycle right after the capture edge: tdo already shows bit L-1.
    task automatic dump_chain(input logic [L-1:0] img, input int nbits, input string nm);
        for (int j = 0; j < nbits; j++) expect_at(j, 1'b1, (N+1)'(img[L-1-j]), nm);
        shift = 1'b1;
        repeat (nbits - 1) step();
        shift = 1'b0;
    endtask

    task automatic capture_dump(input logic [N-1:0] x, input logic [N-1:0] y,
                                input logic ci, input logic sub, input bit both, input string nm);
        apply(x, y, ci, sub, {nm, "_func"});
        step();
        capture = 1'b1;
        shift   = both;
        step();
        capture = 1'b0;
        dump_chain(chain_img(x, y, ci, sub, ref_sum(x, y, ci, sub)), L, nm);
    endtask

    // Monitor
    initial begin : monitor
        exp_t       e;
        logic [N:0] act;
        forever begin
            @(negedge clk);
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].cyc <= cyc) begin
                    e = sbq[i];
                    sbq.delete(i);
                    act = e.is_scan ? (N+1)'(tdo) : {co, sum};
                    checks++;
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL %s missed at cyc %0d (due %0d)", e.name, cyc, e.cyc);
                    end else if (act !== e.exp) begin
                        errors++;
                        $display("FAIL %s cyc %0d got %h want %h", e.name, cyc, act, e.exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [L-1:0] img;
        logic [N:0]   core_res;
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sel = 1'b0; tdi = 1'b0;
        capture = 1'b0; shift = 1'b0; update = 1'b0; test_mode = 1'b0;
        step();
        step();
        expect_at(0, 1'b0, '0, "reset_sum");
        expect_at(0, 1'b1, '0, "reset_tdo");
        step();
        rst_n = 1'b1;

        // Directed add/subtract.
        apply(16'h0000, 16'hFFFF, 1'b0, 1'b0, "add_ffff");
        apply(16'h000F, 16'hFFF1, 1'b0, 1'b0, "add_wrap");
        apply(16'h000F, 16'h0010, 1'b1, 1'b1, "sub_borrow");
        apply(16'h0010, 16'h000F, 1'b0, 1'b1, "sub_noborrow");

        // Random operands with unrelated scan activity on the side.
        for (int k = 0; k < 40; k++) begin
            capture = 1'($urandom); shift = 1'($urandom); update = 1'($urandom);
            tdi = 1'($urandom);
            apply(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand_func");
        end
        capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;

        capture_dump(16'h1234, 16'h00FF, 1'b1, 1'b0, 1'b0, "cap_shift");
        capture_dump(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "cap_rand");
        capture_dump(16'hBEEF, 16'h4321, 1'b0, 1'b1, 1'b1, "cap_and_shift");

        // Shift an image in under test mode, update, then read the core back.
        test_mode = 1'b1;
        img = {1'b1, 16'hA5A5, 1'b0, 1'b0, 16'hFFFF, 16'h0001};
        shift = 1'b1;
        for (int k = 0; k < L; k++) begin
            tdi = img[L-1-k];
            step();
        end
        shift = 1'b0; tdi = 1'b0; update = 1'b1;
        step();
        update = 1'b0;
        expect_at(0, 1'b0, {1'b1, 16'hA5A5}, "ur_drive");
        step();
        capture = 1'b1;
        step();
        capture = 1'b0;
        core_res = ref_sum(16'h0001, 16'hFFFF, 1'b0, 1'b0);
        dump_chain({core_res, {(2*N+2){1'b0}}}, N + 1, "ur_core");

        // Reset in the middle of a shift.
        test_mode = 1'b0;
        capture_dump(16'h1234, 16'h00FF, 1'b1, 1'b0, 1'b0, "pre_rst");
        capture = 1'b1;
        step();
        capture = 1'b0; shift = 1'b1;
        repeat (20) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; shift = 1'b0;
        expect_at(0, 1'b0, '0, "rst_res");
        expect_at(0, 1'b1, '0, "rst_tdo");
        step();
        test_mode = 1'b1;
        expect_at(0, 1'b0, '0, "rst_ur");
        dump_chain('0, L, "rst_sr");

        test_mode = 1'b0;
        for (int k = 0; k < 8; k++)
            apply(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand_tail");
        step();
        step();
        if (sbq.size() != 0) begin
            errors += sbq.size();
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
